// File: rtl/unary_stream_encoder.sv
// Binary-to-unary stream transmitter: accepts a count over valid/ready and emits
// INPUT_WIDTH strobed bits, rate-coded by default. Optional macro UNARY_ENC_MODE_SEL_EN adds a thermometer mode.
module unary_stream_encoder #(
  parameter int INPUT_WIDTH = 32,
  parameter int COUNT_WIDTH = $clog2(INPUT_WIDTH + 1)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [COUNT_WIDTH-1:0] in_value,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic                   enable,
`ifdef UNARY_ENC_MODE_SEL_EN
  input  logic                   mode,
`endif
  output logic                   bit_out,
  output logic                   bit_ready,
  output logic                   busy,
  output logic                   done
);

  typedef enum logic {IDLE, STREAM} state_t;

  localparam logic [COUNT_WIDTH-1:0] LEN_C  = COUNT_WIDTH'(INPUT_WIDTH);
  localparam logic [COUNT_WIDTH-1:0] LAST_C = COUNT_WIDTH'(INPUT_WIDTH - 1);
  localparam logic [COUNT_WIDTH:0]   LEN_A  = (COUNT_WIDTH + 1)'(INPUT_WIDTH);

  state_t                 state, state_n;
  logic [COUNT_WIDTH:0]   acc, acc_n;
  logic [COUNT_WIDTH-1:0] cnt, cnt_n;
  logic [COUNT_WIDTH-1:0] val, val_n;
  logic                   mode_q, mode_n;
  logic                   bit_n, rdy_n, done_n;

  logic [COUNT_WIDTH-1:0] sat_value;
  logic [COUNT_WIDTH:0]   sum;
  logic                   last_bit;
  logic                   mode_in;

`ifdef UNARY_ENC_MODE_SEL_EN
  assign mode_in = mode;
`else
  assign mode_in = 1'b0;
`endif

  assign sat_value = (in_value > LEN_C) ? LEN_C : in_value;
  assign sum       = acc + {1'b0, val};
  assign last_bit  = (state == STREAM) && enable && (cnt == LAST_C);
  // The final-bit cycle doubles as an accept slot so streams can run back to back.
  assign in_ready  = (state == IDLE) || last_bit;
  assign busy      = (state == STREAM) || done;

  // NOTE: every output of this block gets a default first, so no path leaves a value unassigned and no latch is inferred.
  always_comb begin
    state_n = state;
    acc_n   = acc;
    cnt_n   = cnt;
    val_n   = val;
    mode_n  = mode_q;
    bit_n   = 1'b0;
    rdy_n   = 1'b0;
    done_n  = 1'b0;
    case (state)
      IDLE: begin
        if (in_valid) begin
          val_n   = sat_value;
          mode_n  = mode_in;
          acc_n   = '0;
          cnt_n   = '0;
          state_n = STREAM;
        end
      end
      STREAM: begin
        if (enable) begin
          rdy_n = 1'b1;
          cnt_n = cnt + COUNT_WIDTH'(1);
          if (sum >= LEN_A) acc_n = sum - LEN_A;
          else              acc_n = sum;
          bit_n = mode_q ? (cnt < val) : (sum >= LEN_A);
          if (last_bit) begin
            done_n = 1'b1;
            if (in_valid) begin
              val_n  = sat_value;
              mode_n = mode_in;
              acc_n  = '0;
              cnt_n  = '0;
            end else begin
              state_n = IDLE;
            end
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      acc       <= '0;
      cnt       <= '0;
      val       <= '0;
      mode_q    <= 1'b0;
      bit_out   <= 1'b0;
      bit_ready <= 1'b0;
      done      <= 1'b0;
    end else begin
      state     <= state_n;
      acc       <= acc_n;
      cnt       <= cnt_n;
      val       <= val_n;
      mode_q    <= mode_n;
      bit_out   <= bit_n;
      bit_ready <= rdy_n;
      done      <= done_n;
    end
  end

endmodule
